// File: rtl/immext_pipe.sv
// Pipelined MIPS immediate extender (sign / zero / upper / branch) into a 2-entry elastic buffer.
// Latency: result visible on out_data the cycle after accept; 1 transaction/cycle sustained.
// Backpressure: in_ready drops only when both entries are full; registered state only, plus reset.
// Optional feature macro: IMMEXT_BRANCH_EN (mode 11 = sign extend then x4; otherwise same as mode 00).
module immext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam int E = OUT_W - IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } cnt_t;

  cnt_t             state;
  cnt_t             state_nxt;
  logic [OUT_W-1:0] head_dat;
  logic [OUT_W-1:0] tail_dat;
  logic [OUT_W-1:0] sx_dat;
  logic [OUT_W-1:0] zx_dat;
  logic [OUT_W-1:0] up_dat;
  logic [OUT_W-1:0] ext_dat;
  logic             push;
  logic             pop;

  // Candidate extensions; a zero-width pad (E = 0) falls out naturally from the casts.
  assign sx_dat = OUT_W'($signed(in_imm));
  assign zx_dat = OUT_W'(in_imm);
  assign up_dat = zx_dat << E;

  // Select the extension for the incoming transaction; only the selected value is stored.
  always_comb begin
    ext_dat = sx_dat;
    case (in_mode)
      2'b00: ext_dat = sx_dat;
      2'b01: ext_dat = zx_dat;
      2'b10: ext_dat = up_dat;
      default: begin
`ifdef IMMEXT_BRANCH_EN
        ext_dat = sx_dat << 2;
`else
        ext_dat = sx_dat;
`endif
      end
    endcase
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Occupancy next-state: simultaneous push and pop in ONE keeps the count.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs decoded from registered occupancy (reset also blocks accepts).
  always_comb begin
    in_ready  = (state != FULL) && !reset;
    out_valid = (state != EMPTY);
  end

  // Entry storage: head drives out_data directly, tail only fills when head is occupied and held.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_dat <= '0;
      tail_dat <= '0;
    end else begin
      case (state)
        EMPTY: if (push) head_dat <= ext_dat;
        ONE: begin
          if (push && pop) head_dat <= ext_dat;
          else if (push)   tail_dat <= ext_dat;
        end
        FULL:    if (pop) head_dat <= tail_dat;
        default: ;
      endcase
    end
  end

  assign out_data = head_dat;

endmodule

// File: tb/tb_immext_pipe.sv
// Bench for immext_pipe: queue-based reference model checked every cycle, plus literal expectations.
// Covers modes, backpressure, streaming, random handshakes, mid-operation reset, IN_W = OUT_W corner.
// Works in both builds; expected branch-mode values follow IMMEXT_BRANCH_EN.
module tb_immext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  // Second instance for the IN_W = OUT_W corner.
  logic        in_valid2;
  logic        in_ready2;
  logic [15:0] in_imm2;
  logic [1:0]  in_mode2;
  logic        out_valid2;
  logic        out_ready2;
  logic [15:0] out_data2;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  int          push_cnt = 0;
  int          pop_cnt  = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;

  always #5 clk = ~clk;

  immext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  immext_pipe #(.IN_W(16), .OUT_W(16)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_imm(in_imm2), .in_mode(in_mode2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension from the mode rules, using integer arithmetic modulo 2^outw.
  function automatic logic [63:0] ref_ext(input logic [63:0] imm, input int mode,
                                          input int inw, input int outw);
    longint s;
    longint r;
    longint m;
    m = longint'(1) << outw;
    s = longint'(imm);
    if (imm[inw-1]) s = s - (longint'(1) << inw);
    case (mode)
      0: r = s;
      1: r = longint'(imm);
      2: r = longint'(imm) * (longint'(1) << (outw - inw));
`ifdef IMMEXT_BRANCH_EN
      default: r = s * 4;
`else
      default: r = s;
`endif
    endcase
    return 64'(r & (m - 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: checks handshakes and data against the model queue at every negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_stall) chk("stall_hold", 64'(out_data), 64'(prev_dat));
      chk("in_ready", 64'(in_ready), 64'((q.size() != 2) && !reset));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
      if (reset) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        prev_stall = out_valid && !out_ready;
        prev_dat   = out_data;
        if (out_valid && out_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          pop_cnt++;
        end
        if (in_valid && in_ready) begin
          q.push_back(32'(ref_ext(64'(in_imm), int'(in_mode), 16, 32)));
          push_cnt++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_m [4];
  logic [15:0] exp_c [4];
  int          p0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_imm2 = '0; in_mode2 = '0; out_ready2 = 1'b1;
    exp_m[0] = 32'hFFFF_8001; exp_m[1] = 32'h0000_8001; exp_m[2] = 32'h8001_0000;
    exp_c[0] = 16'hABCD;      exp_c[1] = 16'hABCD;      exp_c[2] = 16'hABCD;
`ifdef IMMEXT_BRANCH_EN
    exp_m[3] = 32'hFFFE_0004; exp_c[3] = 16'hAF34;
`else
    exp_m[3] = 32'hFFFF_8001; exp_c[3] = 16'hABCD;
`endif

    // Pin the reference model against hand-computed values.
    for (int m = 0; m < 4; m++) begin
      chk("model_w32", ref_ext(64'h8001, m, 16, 32), 64'(exp_m[m]));
      chk("model_w16", ref_ext(64'hABCD, m, 16, 16), 64'(exp_c[m]));
    end

    // Reset state.
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Modes back to back, each result visible the cycle after accept.
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      in_valid = 1'b1; in_imm = 16'h8001; in_mode = 2'(m);
      step();
      chk("mode_valid", 64'(out_valid), 64'(1));
      chk("mode_data", 64'(out_data), 64'(exp_m[m]));
    end
    in_valid = 1'b0;
    step(); step();

    // Backpressure: two accepts fill the buffer, head held, then drained in order.
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0001; in_mode = 2'b01;
    step();
    in_imm = 16'h0002;
    step();
    in_valid = 1'b0; in_imm = 16'hDEAD; in_mode = 2'b00;
    chk("bp_full_in_ready", 64'(in_ready), 64'(0));
    chk("bp_hold_data", 64'(out_data), 64'h1);
    step();
    chk("bp_still_held", 64'(out_data), 64'h1);
    out_ready = 1'b1;
    step();
    chk("bp_second", 64'(out_data), 64'h2);
    chk("bp_in_ready_back", 64'(in_ready), 64'(1));
    step();
    chk("bp_empty", 64'(out_valid), 64'(0));

    // Streaming: 100 random back-to-back transactions, one result per cycle.
    p0 = pop_cnt;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_imm = 16'($urandom); in_mode = 2'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("stream_count", 64'(pop_cnt - p0), 64'd100);
    step();

    // Random handshake on both sides.
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    step();
    chk("rand_drained", 64'(q.size()), 64'(0));
    chk("rand_no_loss", 64'(pop_cnt), 64'(push_cnt));

    // Reset while FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'b00;
    step();
    in_imm = 16'h5678;
    step();
    in_valid = 1'b0;
    chk("pre_rst_full", 64'(in_ready), 64'(0));
    reset = 1'b1;
    step();
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    #1;
    chk("after_rst_in_ready", 64'(in_ready), 64'(1));
    chk("after_rst_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    in_valid = 1'b1; in_imm = 16'h7FFF; in_mode = 2'b00;
    step();
    in_valid = 1'b0;
    chk("after_rst_data", 64'(out_data), 64'h0000_7FFF);
    step(); step();

    // IN_W = OUT_W corner.
    for (int m = 0; m < 4; m++) begin
      in_valid2 = 1'b1; in_imm2 = 16'hABCD; in_mode2 = 2'(m);
      step();
      in_valid2 = 1'b0;
      chk("corner_valid", 64'(out_valid2), 64'(1));
      chk("corner_data", 64'(out_data2), 64'(exp_c[m]));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
